// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch tick controller.
//   sw_state_e      : controller states IDLE / RUN / PAUSE
//   DIVISOR_DEFAULT : default number of clock cycles per count tick
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam int unsigned DIVISOR_DEFAULT = 10_000_000;

endpackage

// File: rtl/btn_edge_sync.sv
// Button conditioner: two-flop synchronizer, a history flop and a
// rising-edge detector producing a one-cycle press event.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   btn   : raw button level, asynchronous to clock
//   press : one-cycle pulse when the synchronized level goes 0 -> 1
module btn_edge_sync
    import stopwatch_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;

    always_comb begin
        meta_d = btn;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    // All flops reset to 1 so a button held through reset looks like a
    // level that was already high: no event until released and pressed.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign press = sync_q & ~hist_q;

endmodule

// File: rtl/stopwatch_tick_ctrl.sv
// Stopwatch tick controller: start/stop and clear buttons drive an
// IDLE/RUN/PAUSE state machine; a prescaler running only in RUN emits a
// count-enable pulse every DIVISOR run cycles.
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset
//   btn_ss  : start/stop button level (asynchronous)
//   btn_clr : clear button level (asynchronous)
//   inc     : one-cycle count-enable pulse to the units counter
//   clr     : one-cycle clear pulse to all downstream counters
//   running : high while in RUN
//   paused  : high while in PAUSE
module stopwatch_tick_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIVISOR = DIVISOR_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_ss,
    input  logic btn_clr,
    output logic inc,
    output logic clr,
    output logic running,
    output logic paused
);

    localparam int unsigned PRESC_W = $clog2(DIVISOR);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIVISOR - 1);

    sw_state_e          state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               clr_q, clr_d;
    logic               ss_ev, clr_ev;

    btn_edge_sync u_sync_ss (
        .clock (clock),
        .reset (reset),
        .btn   (btn_ss),
        .press (ss_ev)
    );

    btn_edge_sync u_sync_clr (
        .clock (clock),
        .reset (reset),
        .btn   (btn_clr),
        .press (clr_ev)
    );

    // Next state and clear pulse. Clear has priority in IDLE and PAUSE;
    // RUN ignores clear entirely so start/stop always wins there.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_ev) begin
                    clr_d = 1'b1;
                end else if (ss_ev) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ss_ev) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (clr_ev) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end else if (ss_ev) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler advances on every RUN cycle (including the one in which
    // a pause is accepted), holds across PAUSE, and is cleared on the way
    // into IDLE so a restart always begins a full tick.
    always_comb begin
        presc_d = presc_q;
        if (state_d == IDLE) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            clr_q   <= clr_d;
        end
    end

    assign inc     = (state_q == RUN) && (presc_q == PRESC_MAX);
    assign clr     = clr_q;
    assign running = (state_q == RUN);
    assign paused  = (state_q == PAUSE);

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
module tb_stopwatch_tick_ctrl;

    localparam int D = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn_ss = 1'b0;
    logic btn_clr = 1'b0;
    logic inc, clr, running, paused;

    int checks = 0;
    int failures = 0;

    stopwatch_tick_ctrl #(.DIVISOR(D)) dut (
        .clock   (clock),
        .reset   (reset),
        .btn_ss  (btn_ss),
        .btn_clr (btn_clr),
        .inc     (inc),
        .clr     (clr),
        .running (running),
        .paused  (paused)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0=idle 1=run 2=pause; run_total counts RUN
    // cycles since the last clear, a tick falls on every D-th one.
    // Button samples are kept newest-first; an event seen at an edge is a
    // 0->1 step between the samples taken two and three edges earlier.
    int mode = 0;
    int run_total = 0;
    bit ss_h[3] = '{1'b1, 1'b1, 1'b1};
    bit cl_h[3] = '{1'b1, 1'b1, 1'b1};
    bit e_inc = 1'b0;
    bit e_clr = 1'b0;

    function automatic logic [3:0] exp_vec();
        return {e_inc, e_clr, logic'(mode == 1), logic'(mode == 2)};
    endfunction

    task automatic cyc(input bit ss, input bit cl, input bit rs);
        bit sev, cev;
        btn_ss  = ss;
        btn_clr = cl;
        reset   = rs;
        @(posedge clock);
        if (rs) begin
            mode = 0;
            run_total = 0;
            e_clr = 1'b0;
            ss_h = '{1'b1, 1'b1, 1'b1};
            cl_h = '{1'b1, 1'b1, 1'b1};
        end else begin
            sev = ss_h[1] & ~ss_h[2];
            cev = cl_h[1] & ~cl_h[2];
            if (mode == 1) run_total++;
            e_clr = 1'b0;
            case (mode)
                0: if (cev) e_clr = 1'b1; else if (sev) mode = 1;
                1: if (sev) mode = 2;
                default: if (cev) begin mode = 0; e_clr = 1'b1; end
                         else if (sev) mode = 1;
            endcase
            if (mode == 0) run_total = 0;
            ss_h[2] = ss_h[1]; ss_h[1] = ss_h[0]; ss_h[0] = ss;
            cl_h[2] = cl_h[1]; cl_h[1] = cl_h[0]; cl_h[0] = cl;
        end
        e_inc = (mode == 1) && ((run_total % D) == D - 1);
        #1;
    endtask

    // Reset, then one-cycle ss press; returns in the first RUN cycle.
    task automatic start_run();
        cyc(0, 0, 1); cyc(0, 0, 1);
        cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    endtask

    task automatic test_reset();
        cyc(0, 0, 1); cyc(0, 0, 1);
        checks++;
        if ({inc, clr, running, paused} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state got=%b want=0000", {inc, clr, running, paused});
        end
        cyc(0, 0, 0);
        checks++;
        if ({inc, clr, running, paused} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle got=%b want=0000", {inc, clr, running, paused});
        end
    endtask

    task automatic test_run_ticks();
        cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 0);
        cyc(1, 0, 0); cyc(0, 0, 0);
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL ss_latency_early running=%b want=0", running);
        end
        cyc(0, 0, 0);
        checks++;
        if ({inc, running} !== 2'b01) begin
            failures++;
            $display("FAIL ss_latency {inc,running}=%b want=01", {inc, running});
        end
        for (int k = 2; k <= 14; k++) begin
            cyc(0, 0, 0);
            checks++;
            if ({inc, running} !== {logic'(k % 4 == 0), 1'b1}) begin
                failures++;
                $display("FAIL run_tick cycle=%0d {inc,running}=%b want=%b",
                         k, {inc, running}, {logic'(k % 4 == 0), 1'b1});
            end
        end
    endtask

    task automatic test_pause_resume();
        start_run();
        for (int k = 2; k <= 4; k++) cyc(k == 4, 0, 0);
        checks++;
        if (inc !== 1'b1) begin
            failures++;
            $display("FAIL pause_pre_inc inc=%b want=1", inc);
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({inc, running, paused} !== 3'b001) begin
                failures++;
                $display("FAIL pause_hold cycle=%0d {inc,running,paused}=%b want=001",
                         k, {inc, running, paused});
            end
            cyc(0, 0, 0);
        end
        cyc(1, 0, 0); cyc(0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 0);
            checks++;
            if ({inc, running} !== {logic'(k == 3), 1'b1}) begin
                failures++;
                $display("FAIL resume_tick cycle=%0d {inc,running}=%b want=%b",
                         k, {inc, running}, {logic'(k == 3), 1'b1});
            end
        end
    endtask

    task automatic test_clear();
        start_run();
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(0, 1, 0); cyc(0, 0, 0);
        checks++;
        if ({clr, paused} !== 2'b01) begin
            failures++;
            $display("FAIL clr_pause_early {clr,paused}=%b want=01", {clr, paused});
        end
        cyc(0, 0, 0);
        checks++;
        if ({inc, clr, running, paused} !== 4'b0100) begin
            failures++;
            $display("FAIL clr_pause got=%b want=0100", {inc, clr, running, paused});
        end
        cyc(0, 0, 0);
        checks++;
        if ({inc, clr, running, paused} !== 4'b0000) begin
            failures++;
            $display("FAIL clr_pulse_width got=%b want=0000", {inc, clr, running, paused});
        end
        // restart after clear must take a full D cycles to the first tick
        cyc(1, 0, 0); cyc(0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 0, 0);
            checks++;
            if ({inc, running} !== {logic'(k == 4), 1'b1}) begin
                failures++;
                $display("FAIL clr_restart cycle=%0d {inc,running}=%b want=%b",
                         k, {inc, running}, {logic'(k == 4), 1'b1});
            end
        end
        start_run();
        cyc(0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0);
            checks++;
            if ({clr, running, paused} !== 3'b010) begin
                failures++;
                $display("FAIL clr_in_run cycle=%0d {clr,running,paused}=%b want=010",
                         k, {clr, running, paused});
            end
        end
    endtask

    task automatic test_simultaneous();
        start_run();
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        checks++;
        if ({inc, clr, running, paused} !== 4'b0100) begin
            failures++;
            $display("FAIL both_in_pause got=%b want=0100", {inc, clr, running, paused});
        end
        start_run();
        cyc(1, 1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        checks++;
        if ({clr, running, paused} !== 3'b001) begin
            failures++;
            $display("FAIL both_in_run {clr,running,paused}=%b want=001", {clr, running, paused});
        end
    endtask

    task automatic test_held_through_reset();
        cyc(1, 0, 1); cyc(1, 0, 1);
        for (int k = 0; k < 6; k++) begin
            cyc(1, 0, 0);
            checks++;
            if ({running, paused} !== 2'b00) begin
                failures++;
                $display("FAIL held_ss cycle=%0d {running,paused}=%b want=00",
                         k, {running, paused});
            end
        end
        cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL held_release_press running=%b want=1", running);
        end
    endtask

    task automatic test_reset_mid_run();
        start_run();
        cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(0, 0, 1);
        checks++;
        if ({inc, clr, running, paused} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_run got=%b want=0000", {inc, clr, running, paused});
        end
        cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 0, 0);
            checks++;
            if ({inc, clr, running} !== {logic'(k == 4), 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL reset_restart cycle=%0d {inc,clr,running}=%b want=%b",
                         k, {inc, clr, running}, {logic'(k == 4), 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_random();
        bit ss_lvl = 1'b0;
        bit cl_lvl = 1'b0;
        bit rs;
        cyc(0, 0, 1);
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 5) == 0) ss_lvl = ~ss_lvl;
            if ($urandom_range(0, 9) == 0) cl_lvl = ~cl_lvl;
            rs = ($urandom_range(0, 299) == 0);
            cyc(ss_lvl, cl_lvl, rs);
            checks++;
            if ({inc, clr, running, paused} !== exp_vec()) begin
                failures++;
                $display("FAIL random cycle=%0d {inc,clr,running,paused}=%b want=%b",
                         k, {inc, clr, running, paused}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_pause_resume();
        test_clear();
        test_simultaneous();
        test_held_through_reset();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_tick_ctrl.md
STOPWATCH_TICK_CTRL -- requirements
Module: stopwatch_tick_ctrl

Interface
REQ-001 The block SHALL have one parameter, DIVISOR, default 10_000_000: clock cycles per count tick, legal range 2 or more.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port btn_ss, input, 1 bit: start/stop button level, asynchronous to clock.
REQ-005 The block SHALL have port btn_clr, input, 1 bit: clear button level, asynchronous to clock.
REQ-006 The block SHALL have port inc, output, 1 bit: one-cycle count-enable pulse to the downstream units counter.
REQ-007 The block SHALL have port clr, output, 1 bit: one-cycle clear pulse driving the reset input of every downstream counter.
REQ-008 The block SHALL have port running, output, 1 bit: high while in state RUN.
REQ-009 The block SHALL have port paused, output, 1 bit: high while in state PAUSE.

Function
REQ-010 The block SHALL pass each button through a two-flop synchronizer followed by a history flop, and SHALL raise a press event in a cycle where the synchronized level is 1 and the history flop is 0.
REQ-011 A button rising before clock edge N SHALL change state at edge N+2; held buttons SHALL produce exactly one event.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-013 In IDLE: an ss event SHALL go to RUN, and a clr event SHALL stay in IDLE and emit a clr pulse.
REQ-014 In RUN: an ss event SHALL go to PAUSE, and a clr event SHALL be ignored.
REQ-015 In PAUSE: an ss event SHALL go to RUN, and a clr event SHALL go to IDLE and emit a clr pulse.
REQ-016 On simultaneous ss and clr events, clr SHALL win in IDLE and PAUSE, and ss SHALL win in RUN.
REQ-017 The prescaler SHALL count 0..DIVISOR-1 only in RUN and SHALL wrap to 0 after DIVISOR-1.
REQ-018 The prescaler SHALL hold its value in PAUSE and SHALL be forced to 0 in IDLE.
REQ-019 inc SHALL be 1 for exactly the one cycle where the state is RUN and the prescaler equals DIVISOR-1; otherwise inc SHALL be 0.
REQ-020 After IDLE->RUN, the first inc SHALL occur in the DIVISOR-th RUN cycle, and subsequent inc pulses SHALL be exactly DIVISOR cycles apart.
REQ-021 After PAUSE->RUN, the next inc SHALL occur after the remaining (DIVISOR-1-held) RUN cycles plus one, so no sub-tick time is lost.
REQ-022 clr SHALL be registered and high for exactly the one cycle after the edge that accepts the clr event; inc and clr SHALL never both be 1.
REQ-023 running and paused SHALL be decoded directly from the state register, with no added latency, and SHALL never both be 1.

Reset
REQ-024 reset sampled high SHALL on that edge force: state IDLE; prescaler 0; inc 0; clr 0; running 0; paused 0.
REQ-025 reset SHALL force all synchronizer and history flops to 1, so a button held across reset deassertion produces no event until it is released and pressed again.
REQ-026 reset asserted mid-RUN or mid-PAUSE SHALL abort immediately and SHALL emit no clr pulse.

Structure
REQ-027 Package stopwatch_pkg SHALL hold the FSM state typedef (IDLE/RUN/PAUSE) and the DIVISOR default constant.
REQ-028 The prescaler width SHALL be $clog2(DIVISOR), defined in the module.
REQ-029 Sub-module btn_edge_sync (synchronizer, history flop and rising-edge detect, with clock and reset ports) SHALL be instantiated twice, once per button.

Verification (DIVISOR=4)
REQ-030 Reset, then btn_ss high for 1 cycle before edge N -> running=1 after N+2; inc high in RUN cycles 4, 8, 12; no other inc.
REQ-031 Press ss 2 cycles after an inc -> paused=1, prescaler held at 1, no inc for 20 cycles; press ss again -> inc exactly 3 RUN cycles later.
REQ-032 clr press in PAUSE -> clr high for 1 cycle, state IDLE, prescaler 0; clr press in RUN -> no clr pulse, state unchanged.
REQ-033 ss and clr pressed in the same cycle: in PAUSE -> IDLE plus one clr pulse; in RUN -> PAUSE with clr=0.
REQ-034 btn_ss held high through reset deassertion -> no state change; release, then press -> RUN.
REQ-035 reset pulsed for 1 cycle mid-RUN -> the next cycle shows IDLE, inc=0, clr=0, and the prescaler at 0.
